led_pwm_dimmer: RTL and testbench

Parametrised multi-channel LED brightness controller for the board top level. Each of CHANNELS logic signals drives one LED through a per-channel PWM duty cycle. Three raw push-buttons select a channel and step its brightness up or down. Button inputs are synchronised and debounced. Duty changes take effect only at PWM period boundaries, so LEDs never glitch.

---
 rtl/led_pwm_dimmer.sv | 188 ++++++++++++++++++
 tb/tb_led_pwm_dimmer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// led_pwm_dimmer
//
// Multi-channel LED brightness controller. Three raw push-buttons pass through
// 2-flop synchronisers and debouncers. Their press events select a channel and
// step its target duty up or down with saturation. Each channel's PWM compare
// uses an active (shadow) duty. The active duty reloads from the target only
// when the free-running PWM counter wraps, so a period in progress never
// glitches.
//
// Parameters:
//   CHANNELS        number of LED channels (1..16)
//   PWM_BITS        PWM counter width, period = 2^PWM_BITS cycles
//   DEFAULT_DUTY    per-channel duty after reset (0..2^PWM_BITS)
//   STEP            duty change per UP/DN press
//   DEBOUNCE_CYCLES stable cycles needed before a button change is accepted
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   BTN_SEL  in   raw button, advances the selected channel
//   BTN_UP   in   raw button, raises duty of the selected channel
//   BTN_DN   in   raw button, lowers duty of the selected channel
//   GATE     in   per-channel enable; an LED lights only while its bit is 1
//   LED      out  registered PWM-gated outputs
//   SEL_CH   out  index of the selected channel
// -----------------------------------------------------------------------------
module led_pwm_dimmer #(
    parameter int CHANNELS        = 5,
    parameter int PWM_BITS        = 8,
    parameter int DEFAULT_DUTY    = 8,
    parameter int STEP            = 8,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BTN_SEL,
    input  logic                BTN_UP,
    input  logic                BTN_DN,
    input  logic [CHANNELS-1:0] GATE,
    output logic [CHANNELS-1:0] LED,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] SEL_CH
);

    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DUTY_W   = PWM_BITS + 1;
    localparam int ARITH_W  = PWM_BITS + 2;
    localparam int CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DUTY_MAX = 2 ** PWM_BITS;
    localparam int NBTN     = 3;

    localparam logic [DUTY_W-1:0]   DUTY_RESET = DUTY_W'(DEFAULT_DUTY);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = {PWM_BITS{1'b1}};
    localparam logic [CNT_W-1:0]    DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_W-1:0]    SEL_LAST   = SEL_W'(CHANNELS - 1);

    // Button bit positions inside the packed button vectors.
    localparam int B_SEL = 0;
    localparam int B_UP  = 1;
    localparam int B_DN  = 2;

    // Saturating duty step. Arithmetic runs one bit wider than the duty so the
    // sum can exceed full scale before clamping. UP together with DN cancels.
    function automatic logic [DUTY_W-1:0] adjust_duty(
        input logic [DUTY_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [ARITH_W-1:0] wide;
        logic [ARITH_W-1:0] step_w;
        logic [ARITH_W-1:0] full_w;
        logic [ARITH_W-1:0] result;
        wide   = {1'b0, cur};
        step_w = ARITH_W'(STEP);
        full_w = ARITH_W'(DUTY_MAX);
        if (inc && !dec) begin
            result = wide + step_w;
            if (result > full_w) begin
                result = full_w;
            end
        end else if (dec && !inc) begin
            if (wide < step_w) begin
                result = {ARITH_W{1'b0}};
            end else begin
                result = wide - step_w;
            end
        end else begin
            result = wide;
        end
        return DUTY_W'(result);
    endfunction

    logic [NBTN-1:0]     btn_raw_s;
    logic [NBTN-1:0]     sync1_r;
    logic [NBTN-1:0]     sync2_r;
    logic [NBTN-1:0]     stable_r;
    logic [NBTN-1:0]     press_r;
    logic [CNT_W-1:0]    db_cnt_r [NBTN];

    logic [SEL_W-1:0]    sel_ch_r;
    logic [DUTY_W-1:0]   target_r [CHANNELS];
    logic [DUTY_W-1:0]   active_r [CHANNELS];
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [CHANNELS-1:0] led_r;

    assign btn_raw_s = {BTN_DN, BTN_UP, BTN_SEL};
    assign LED       = led_r;
    assign SEL_CH    = sel_ch_r;

    // Synchronise, debounce and detect presses for the three buttons.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r  <= 3'b000;
            sync2_r  <= 3'b000;
            stable_r <= 3'b000;
            press_r  <= 3'b000;
            for (int b = 0; b < NBTN; b++) begin
                db_cnt_r[b] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int b = 0; b < NBTN; b++) begin
                if (sync2_r[b] != stable_r[b]) begin
                    if (db_cnt_r[b] == DB_LAST) begin
                        // Accept the change. Only a 0->1 flip is a press.
                        stable_r[b] <= ~stable_r[b];
                        db_cnt_r[b] <= {CNT_W{1'b0}};
                        press_r[b]  <= ~stable_r[b];
                    end else begin
                        db_cnt_r[b] <= db_cnt_r[b] + CNT_W'(1);
                        press_r[b]  <= 1'b0;
                    end
                end else begin
                    // Any return to the stable level restarts the count.
                    db_cnt_r[b] <= {CNT_W{1'b0}};
                    press_r[b]  <= 1'b0;
                end
            end
        end
    end

    // Apply press events: adjust the currently selected target, then advance selection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_ch_r <= {SEL_W{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                target_r[i] <= DUTY_RESET;
            end
        end else begin
            // The adjustment uses the old sel_ch_r, so SEL+UP changes the old channel.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_ch_r == SEL_W'(i)) begin
                    target_r[i] <= adjust_duty(target_r[i], press_r[B_UP], press_r[B_DN]);
                end
            end
            if (press_r[B_SEL]) begin
                if (sel_ch_r == SEL_LAST) begin
                    sel_ch_r <= {SEL_W{1'b0}};
                end else begin
                    sel_ch_r <= sel_ch_r + SEL_W'(1);
                end
            end
        end
    end

    // Free-running PWM counter, wrap-time shadow reload and registered LED compare.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            led_r     <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= DUTY_RESET;
            end
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                // Reload only at the last count, so the next period starts with the new duty.
                if (pwm_cnt_r == PWM_LAST) begin
                    active_r[i] <= target_r[i];
                end
                // The extra compare bit lets a duty of 2^PWM_BITS mean always on.
                led_r[i] <= ({1'b0, pwm_cnt_r} < active_r[i]) & GATE[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_dimmer
//
// Self-checking bench for led_pwm_dimmer with PWM_BITS=4, DEBOUNCE_CYCLES=4.
// Expected duties come from a per-channel model that tracks the selected channel
// and target duties with min/max arithmetic. Observed duty is the number of LED
// high cycles in a 16-cycle window.
// -----------------------------------------------------------------------------
module tb_led_pwm_dimmer;

    localparam int CH     = 5;
    localparam int PB     = 4;
    localparam int DD     = 8;
    localparam int ST     = 8;
    localparam int DC     = 4;
    localparam int PERIOD = 16;
    localparam int DMAX   = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BTN_SEL = 1'b0;
    logic          BTN_UP  = 1'b0;
    logic          BTN_DN  = 1'b0;
    logic [CH-1:0] GATE = {CH{1'b1}};
    logic [CH-1:0] LED;
    logic [2:0]    SEL_CH;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hi_cnt   [CH];
    int m_target [CH];
    int m_sel;

    led_pwm_dimmer #(
        .CHANNELS(CH), .PWM_BITS(PB), .DEFAULT_DUTY(DD), .STEP(ST), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_SEL(BTN_SEL), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
        .GATE(GATE), .LED(LED), .SEL_CH(SEL_CH)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic model_reset();
        m_sel = 0;
        for (int i = 0; i < CH; i++) m_target[i] = DD;
    endtask

    task automatic model_apply(input bit s, input bit u, input bit d);
        if (u && !d) m_target[m_sel] = (m_target[m_sel] + ST > DMAX) ? DMAX : m_target[m_sel] + ST;
        else if (d && !u) m_target[m_sel] = (m_target[m_sel] < ST) ? 0 : m_target[m_sel] - ST;
        if (s) m_sel = (m_sel + 1) % CH;
    endtask

    task automatic do_reset();
        RST = 1'b1; BTN_SEL = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        cyc = 0;
        model_reset();
    endtask

    // Hold buttons long enough to debounce, then release and let the release settle.
    task automatic press(input bit s, input bit u, input bit d);
        BTN_SEL = s; BTN_UP = u; BTN_DN = d;
        repeat (8) tick();
        BTN_SEL = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
        repeat (8) tick();
    endtask

    // Let any target change reach the active duty, then count highs over one period.
    task automatic measure_all();
        repeat (34) tick();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        repeat (PERIOD) begin
            tick();
            for (int i = 0; i < CH; i++) hi_cnt[i] += int'(LED[i]);
        end
    endtask

    task automatic test_reset();
        logic [CH-1:0] exp_led;
        GATE = {CH{1'b1}};
        RST = 1'b1; BTN_SEL = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
        repeat (3) begin
            tick();
            n_checks++;
            if (LED !== {CH{1'b0}} || SEL_CH !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_hold: LED=%b SEL_CH=%0d expected LED=0 SEL_CH=0", LED, SEL_CH);
            end
        end
        RST = 1'b0;
        cyc = 0;
        model_reset();
        repeat (2 * PERIOD) begin
            tick();
            // LED after edge k reflects counter value (k-1) mod 16.
            exp_led = (((cyc - 1) % PERIOD) < DD) ? {CH{1'b1}} : {CH{1'b0}};
            n_checks++;
            if (LED !== exp_led) begin
                n_fail++;
                $display("FAIL reset_pwm cyc=%0d: LED=%b expected=%b", cyc, LED, exp_led);
            end
        end
    endtask

    task automatic test_debounce();
        do_reset();
        BTN_UP = 1'b1;
        repeat (3) tick();
        BTN_UP = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (dut.target_r[0] !== 5'd8) begin
            n_fail++;
            $display("FAIL debounce_short: target0=%0d expected=8", dut.target_r[0]);
        end
        BTN_UP = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) begin
                n_checks++;
                if (dut.target_r[0] !== 5'd8) begin
                    n_fail++;
                    $display("FAIL debounce_early: target0=%0d expected=8 at cycle 6", dut.target_r[0]);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (dut.target_r[0] !== 5'd16) begin
                    n_fail++;
                    $display("FAIL debounce_latency: target0=%0d expected=16 at cycle 7", dut.target_r[0]);
                end
            end
        end
        BTN_UP = 1'b0;
        repeat (8) tick();
        model_apply(1'b0, 1'b1, 1'b0);
        measure_all();
        for (int i = 0; i < CH; i++) begin
            n_checks++;
            if (hi_cnt[i] != m_target[i]) begin
                n_fail++;
                $display("FAIL debounce_duty ch%0d: high=%0d expected=%0d", i, hi_cnt[i], m_target[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (3) begin
            press(1'b0, 1'b1, 1'b0);
            model_apply(1'b0, 1'b1, 1'b0);
        end
        measure_all();
        n_checks++;
        if (hi_cnt[0] != m_target[0]) begin
            n_fail++;
            $display("FAIL sat_up: high=%0d expected=%0d", hi_cnt[0], m_target[0]);
        end
        repeat (5) begin
            press(1'b0, 1'b0, 1'b1);
            model_apply(1'b0, 1'b0, 1'b1);
        end
        measure_all();
        n_checks++;
        if (hi_cnt[0] != m_target[0]) begin
            n_fail++;
            $display("FAIL sat_dn: high=%0d expected=%0d", hi_cnt[0], m_target[0]);
        end
        n_checks++;
        if (dut.target_r[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL sat_floor: target0=%0d expected=0", dut.target_r[0]);
        end
    endtask

    task automatic test_select();
        do_reset();
        for (int k = 0; k < CH; k++) begin
            press(1'b1, 1'b0, 1'b0);
            model_apply(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (int'(SEL_CH) != m_sel) begin
                n_fail++;
                $display("FAIL sel_wrap step%0d: SEL_CH=%0d expected=%0d", k, SEL_CH, m_sel);
            end
        end
        repeat (2) begin
            press(1'b1, 1'b0, 1'b0);
            model_apply(1'b1, 1'b0, 1'b0);
        end
        press(1'b1, 1'b1, 1'b0);
        model_apply(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (int'(SEL_CH) != m_sel) begin
            n_fail++;
            $display("FAIL sel_up_sel: SEL_CH=%0d expected=%0d", SEL_CH, m_sel);
        end
        press(1'b0, 1'b1, 1'b1);
        model_apply(1'b0, 1'b1, 1'b1);
        measure_all();
        for (int i = 0; i < CH; i++) begin
            n_checks++;
            if (hi_cnt[i] != m_target[i]) begin
                n_fail++;
                $display("FAIL sel_duty ch%0d: high=%0d expected=%0d", i, hi_cnt[i], m_target[i]);
            end
        end
    endtask

    task automatic test_glitch_free();
        int k0;
        int c1;
        int c2;
        int old_duty;
        do_reset();
        GATE = {CH{1'b1}};
        for (int i = 0; i < PERIOD && (cyc % PERIOD) != 13; i++) tick();
        // Raised here, the DN event lands while the counter shows 3.
        k0 = cyc;
        old_duty = m_target[0];
        c1 = 0;
        c2 = 0;
        BTN_DN = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (i == 8) BTN_DN = 1'b0;
            if (i >= 4 && i <= 19) c1 += int'(LED[0]);
            if (i >= 20 && i <= 35) c2 += int'(LED[0]);
        end
        model_apply(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (c1 != old_duty) begin
            n_fail++;
            $display("FAIL glitch_cur_period (k0=%0d): high=%0d expected=%0d", k0, c1, old_duty);
        end
        n_checks++;
        if (c2 != m_target[0]) begin
            n_fail++;
            $display("FAIL glitch_next_period: high=%0d expected=%0d", c2, m_target[0]);
        end
        // Drop GATE[1] when LED[1] would otherwise be high on the next cycle.
        for (int i = 0; i < PERIOD && (cyc % PERIOD) != 2; i++) tick();
        GATE[1] = 1'b0;
        tick();
        n_checks++;
        if (LED[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_off: LED1=%b expected=0", LED[1]);
        end
        c1 = 0;
        repeat (PERIOD) begin
            tick();
            c1 += int'(LED[1]);
        end
        n_checks++;
        if (c1 != 0) begin
            n_fail++;
            $display("FAIL gate_off_period: high=%0d expected=0", c1);
        end
        GATE[1] = 1'b1;
        measure_all();
        n_checks++;
        if (hi_cnt[1] != m_target[1]) begin
            n_fail++;
            $display("FAIL gate_on: high=%0d expected=%0d", hi_cnt[1], m_target[1]);
        end
    endtask

    task automatic test_random();
        int op;
        int exp_hi;
        bit s, u, d;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            // Optional bounce shorter than the debounce window: no event expected.
            if ($urandom_range(0, 1) == 1) begin
                op = $urandom_range(0, 2);
                BTN_SEL = (op == 0); BTN_UP = (op == 1); BTN_DN = (op == 2);
                repeat ($urandom_range(1, DC - 1)) tick();
                BTN_SEL = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
                repeat (4) tick();
            end
            op = $urandom_range(0, 4);
            s = (op == 0) || (op == 4);
            u = (op == 1) || (op == 3) || (op == 4);
            d = (op == 2) || (op == 3);
            press(s, u, d);
            model_apply(s, u, d);
            n_checks++;
            if (int'(SEL_CH) != m_sel) begin
                n_fail++;
                $display("FAIL rand_sel op%0d=%0d: SEL_CH=%0d expected=%0d", n, op, SEL_CH, m_sel);
            end
            GATE = CH'($urandom);
            measure_all();
            for (int i = 0; i < CH; i++) begin
                exp_hi = GATE[i] ? m_target[i] : 0;
                n_checks++;
                if (hi_cnt[i] != exp_hi) begin
                    n_fail++;
                    $display("FAIL rand_duty op%0d ch%0d: high=%0d expected=%0d", n, i, hi_cnt[i], exp_hi);
                end
            end
        end
        GATE = {CH{1'b1}};
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_saturation();
        test_select();
        test_glitch_free();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
